shift_reg_unit: RTL
===================

Name: shift_reg_unit

Overview:
- Clocked universal shift register built on edge-triggered storage. It is the next stage after the gated D latch: the same D/enable data path, but made synchronous to a clock.
- Supports hold, shift right, shift left and parallel load, with true and complement outputs.
- A frame counter pulses frame_done after WIDTH consecutive same-direction shifts, so a downstream serial or parallel stage can pick up a complete word.

Parameters:
- WIDTH, 8, register width in bits; must be 2 or more.
- CNT_W, 3, frame counter width; 2**CNT_W must be at least WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  clock-enable; when 0, all state holds.
- mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sr_in  input  1  serial input for shift right; enters at bit WIDTH-1.
- sl_in  input  1  serial input for shift left; enters at bit 0.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  register contents.
- QC  output  WIDTH  bitwise complement of Q, always equal to ~Q.
- shift_cnt  output  CNT_W  number of consecutive same-direction shifts in the current frame.
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset: one clock (clk), rising edge only. Reset is asynchronous and active-low (rst_n); its polarity and synchronicity are fixed.
- Reset values, applied immediately on rst_n=0 regardless of clk: Q=0, QC=all ones, shift_cnt=0, frame_done=0, internal last_dir=0.
- Reset mid-frame discards any partial frame. The first shift after reset starts a new frame.
- All updates take effect on the rising clk edge where enable=1. Latency is one cycle from the mode/data sample to Q.
- enable=0: Q, shift_cnt and last_dir hold; frame_done is driven 0 on that edge.
- mode 00: Q holds, shift_cnt holds, frame_done=0.
- mode 01: Q <= {sr_in, Q[WIDTH-1:1]}.
- mode 10: Q <= {Q[WIDTH-2:0], sl_in}.
- mode 11: Q <= D; shift_cnt <= 0; frame_done=0; last_dir unchanged.
- Frame counter, applied on each enabled shift (mode 01 or 10). Direction is 0 for right, 1 for left.
  - If a frame is in progress (shift_cnt != 0) and the direction differs from last_dir: shift_cnt <= 1 and frame_done=0. The direction change restarts the frame, and this shift counts as its first.
  - Otherwise, if shift_cnt == WIDTH-1: shift_cnt <= 0 (wrap) and frame_done <= 1 on the same edge. Q then holds the completed word.
  - Otherwise: shift_cnt <= shift_cnt+1 and frame_done=0.
  - last_dir <= current direction.
- frame_done is registered. It is high only for the cycle following the completing edge and never for two consecutive cycles unless a WIDTH=… back-to-back frame completes, which cannot happen because WIDTH ≥ 2.
- Continuous same-direction shifting produces a frame_done pulse every WIDTH enabled shifts. Holds and disabled cycles between shifts do not break a frame.
- No X propagation: unknown mode values are treated as hold.

Test Plan:
1. Reset and load: rst_n=0 asynchronously mid-cycle → Q=00, QC=FF, shift_cnt=0 immediately. Release, then mode=11 with D=A5 → Q=A5 and QC=5A after one edge.
2. Shift right, full frame: Q=00, mode=01, sr_in pattern 1,0,1,1,0,0,1,0 over 8 edges → Q=4D, shift_cnt goes 1..7 then 0, frame_done high exactly one cycle after the 8th edge.
3. Shift left with gaps: Q=81, mode=10, sl_in=1, with enable toggled low every other cycle → Q=03 after the first shift. shift_cnt frozen during enable=0, frame_done after the 8th enabled shift with Q=FF.
4. Direction change: 3 right shifts (shift_cnt=3), then 1 left shift → shift_cnt=1, frame_done stays 0; 7 further left shifts → frame_done pulse.
5. Load mid-frame: 5 shifts (shift_cnt=5), then mode=11 with D=3C → Q=3C, shift_cnt=0, no frame_done pulse; 8 further shifts → exactly one pulse.
6. Reset mid-frame: shift_cnt=6, assert rst_n=0 between edges → Q=00 and shift_cnt=0 at once; after release, 8 shifts are needed for frame_done.

Source files
------------

// File: rtl/shift_reg_unit.sv
// shift_reg_unit: clocked universal shift register with a frame counter
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   enable     clock enable; when low all state holds and frame_done drops
//   mode       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sr_in      serial input for shift right, enters at bit WIDTH-1
//   sl_in      serial input for shift left, enters at bit 0
//   D          parallel load data
//   Q / QC     register contents and its complement
//   shift_cnt  consecutive same-direction shifts in the current frame
//   frame_done one-cycle pulse after the edge that completes a frame
module shift_reg_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             sr_in,
    input  logic             sl_in,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QC,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);
    logic last_dir;
    logic dir;
    logic restart;
    logic wrap;
    // mode[1] is 1 only for a left shift among the two shift codes
    assign dir     = mode[1];
    assign restart = (shift_cnt != '0) && (dir != last_dir);
    assign wrap    = shift_cnt == CNT_W'(WIDTH - 1);
    assign QC      = ~Q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q          <= '0;
            shift_cnt  <= '0;
            frame_done <= 1'b0;
            last_dir   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (enable) begin
                // unknown or hold codes fall to default and leave state untouched
                case (mode)
                    2'b01, 2'b10: begin
                        Q         <= mode[0] ? {sr_in, Q[WIDTH-1:1]} : {Q[WIDTH-2:0], sl_in};
                        last_dir  <= dir;
                        // a direction change restarts the frame with this shift as its first
                        shift_cnt <= restart ? CNT_W'(1) : wrap ? '0 : shift_cnt + CNT_W'(1);
                        frame_done <= !restart && wrap;
                    end
                    2'b11: begin
                        Q         <= D;
                        shift_cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
